obj_shift_seq: RTL
==================

OBJ_SHIFT_SEQ -- requirements
Module: obj_shift_seq

Interface
REQ-001 SHALL have parameter PIX_BITS, default 4, bits per pixel.
REQ-002 SHALL have parameter TILE_W, default 8, pixels per tile row (power of two, 2..16).
REQ-003 SHALL have parameter ADDR_W, default 9, line-buffer address width.
REQ-004 SHALL have port clk  input  1  system clock; all state on its rising edge.
REQ-005 SHALL have port Reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port Cen  input  1  pixel clock enable; only its 0->1 transition, sampled on clk, is a pixel tick.
REQ-007 SHALL have port line_start  input  1  line boundary pulse, sampled on clk.
REQ-008 SHALL have port tile_valid  input  1  tile row offered.
REQ-009 SHALL have port tile_ready  output  1  sequencer can accept a tile on this tick.
REQ-010 SHALL have port tile_data  input  TILE_W*PIX_BITS  packed pixels, pixel 0 in LSBs.
REQ-011 SHALL have port tile_flip  input  1  horizontal flip: emit pixel TILE_W-1 first.
REQ-012 SHALL have port tile_x  input  ADDR_W  line-buffer address of first emitted pixel.
REQ-013 SHALL have port pix_out  output  PIX_BITS  pixel to write.
REQ-014 SHALL have port pix_addr  output  ADDR_W  write address.
REQ-015 SHALL have port pix_we  output  1  single-clk write strobe.
REQ-016 SHALL have port buf_sel  output  1  line buffer being written (0=A, 1=B); display reads the other.
REQ-017 SHALL have port busy  output  1  high while in SHIFT.

Function
REQ-018 Tick SHALL be Cen & ~last_cen, last_cen registered every clk.
REQ-019 States SHALL be IDLE and SHIFT; pixel counter cnt 0..TILE_W-1.
REQ-020 tile_ready SHALL be combinational: (IDLE) or (SHIFT and cnt==TILE_W-1), and low when line_start is high.
REQ-021 Transfer SHALL occur only on tick & tile_valid & tile_ready; tile_valid outside a tick is ignored, no transfer.
REQ-022 On transfer SHALL load shifter, latch flip, set address to tile_x, cnt=0, enter SHIFT.
REQ-023 On each tick in SHIFT SHALL register pix_out (pixel cnt, or TILE_W-1-cnt if flip), pix_addr, pix_we=1, then address+1, cnt+1.
REQ-024 First pixel SHALL be written on the tick after transfer; a tile occupies exactly TILE_W ticks.
REQ-025 pix_we SHALL be high for exactly one clk after the write tick, then low.
REQ-026 On the last pixel tick with a transfer, SHALL reload with no bubble tick; otherwise return to IDLE.
REQ-027 pix_addr SHALL wrap modulo 2^ADDR_W.
REQ-028 line_start SHALL toggle buf_sel, force IDLE, cnt=0; it wins over a simultaneous tick/transfer; the pending pixel is dropped.
REQ-029 Outputs SHALL hold value between ticks except pix_we.

Reset
REQ-030 On Reset_n=0 at clk: IDLE, cnt=0, last_cen=1, buf_sel=0, pix_we=0, pix_out=0, pix_addr=0, busy=0.
REQ-031 Reset mid-tile SHALL abandon the tile with no further writes; first tick after reset SHALL need Cen low then high.

Configuration
REQ-032 Macro OBJ_SEQ_TRANSP_EN: when defined, pixels equal to 0 SHALL not assert pix_we (address still advances); when undefined, every pixel is written.

Structure
REQ-033 Package obj_seq_pkg SHALL hold the state enum and default parameter constants.
REQ-034 Tick detection SHALL be sub-module cen_rise_det (clk, Reset_n, Cen -> tick).

Verification
REQ-035 Cen toggling, tile 0x87654321, tile_x=10, no flip -> writes 1..8 at 10..17, one per tick.
REQ-036 Same tile, flip=1 -> writes 8,7..1 at 10..17.
REQ-037 Two tiles back-to-back (tile_x 0, 8) -> 16 consecutive write ticks, no gap.
REQ-038 tile_x=510 -> addresses 510,511,0..5.
REQ-039 line_start on 4th pixel tick -> 3 writes only, buf_sel toggles, IDLE, tile_ready high next tick.
REQ-040 OBJ_SEQ_TRANSP_EN defined, tile 0x10203040 -> pix_we on 4 pixels only; undefined -> 8.

Source files
------------

// File: rtl/obj_seq_pkg.sv
// Shared types and default parameters for the object-tile shift sequencer.
package obj_seq_pkg;

    localparam int PIX_BITS_DEF = 4;
    localparam int TILE_W_DEF   = 8;
    localparam int ADDR_W_DEF   = 9;

    // IDLE waits for a tile; SHIFT emits one pixel per pixel tick.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } seq_state_t;

endpackage

// File: rtl/obj_shift_seq_cen_rise_det.sv
// Pixel-tick detector: a tick is the 0->1 transition of Cen seen on clk.
// last_cen resets high so Cen must be seen low before the first tick.
module cen_rise_det (
    input  logic clk,
    input  logic Reset_n,
    input  logic Cen,
    output logic tick
);

    logic last_cen;

    // Remember the previous clk's Cen level.
    always_ff @(posedge clk) begin
        if (!Reset_n) last_cen <= 1'b1;
        else          last_cen <= Cen;
    end

    assign tick = Cen & ~last_cen;

endmodule

// File: rtl/obj_shift_seq.sv
// Object tile shift sequencer: accepts one packed tile row per pixel tick
// handshake and writes its pixels into the active line buffer, one per tick.
// Handshake: a tile transfers on a clk where tick, tile_valid and tile_ready
// are all high; tile_valid on any other clk is ignored.
// Optional macro OBJ_SEQ_TRANSP_EN: zero pixels do not raise pix_we.
module obj_shift_seq
    import obj_seq_pkg::*;
#(
    parameter int PIX_BITS = PIX_BITS_DEF,
    parameter int TILE_W   = TILE_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic                       clk,
    input  logic                       Reset_n,
    input  logic                       Cen,
    input  logic                       line_start,
    input  logic                       tile_valid,
    output logic                       tile_ready,
    input  logic [TILE_W*PIX_BITS-1:0] tile_data,
    input  logic                       tile_flip,
    input  logic [ADDR_W-1:0]          tile_x,
    output logic [PIX_BITS-1:0]        pix_out,
    output logic [ADDR_W-1:0]          pix_addr,
    output logic                       pix_we,
    output logic                       buf_sel,
    output logic                       busy
);

    localparam int CNT_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TILE_W - 1);

    seq_state_t                 state, state_nx;
    logic [CNT_W-1:0]           cnt, cnt_nx;
    logic [TILE_W*PIX_BITS-1:0] tile_q, tile_nx;
    logic                       flip_q, flip_nx;
    logic [ADDR_W-1:0]          addr_q, addr_nx;
    logic [PIX_BITS-1:0]        pix_out_nx;
    logic [ADDR_W-1:0]          pix_addr_nx;
    logic                       pix_we_nx;
    logic                       buf_sel_nx;
    logic                       tick;
    logic                       at_last;
    logic                       transfer;
    logic [CNT_W-1:0]           pix_idx;
    logic [PIX_BITS-1:0]        cur_pix;

    cen_rise_det u_tick (
        .clk     (clk),
        .Reset_n (Reset_n),
        .Cen     (Cen),
        .tick    (tick)
    );

    assign at_last    = (state == ST_SHIFT) && (cnt == CNT_LAST);
    assign tile_ready = ((state == ST_IDLE) || at_last) && !line_start;
    assign transfer   = tick && tile_valid && tile_ready;
    assign busy       = (state == ST_SHIFT);
    assign pix_idx    = flip_q ? (CNT_LAST - cnt) : cnt;
    assign cur_pix    = tile_q[int'(pix_idx)*PIX_BITS +: PIX_BITS];

    // Next-state and datapath decode; line_start overrides any tick work.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        tile_nx     = tile_q;
        flip_nx     = flip_q;
        addr_nx     = addr_q;
        pix_out_nx  = pix_out;
        pix_addr_nx = pix_addr;
        pix_we_nx   = 1'b0;
        buf_sel_nx  = buf_sel;
        if (line_start) begin
            state_nx   = ST_IDLE;
            cnt_nx     = '0;
            buf_sel_nx = ~buf_sel;
        end else if (tick) begin
            if (state == ST_SHIFT) begin
                pix_out_nx  = cur_pix;
                pix_addr_nx = addr_q;
`ifdef OBJ_SEQ_TRANSP_EN
                pix_we_nx   = (cur_pix != '0);
`else
                pix_we_nx   = 1'b1;
`endif
                addr_nx     = addr_q + ADDR_W'(1);
                cnt_nx      = cnt + CNT_W'(1);
                if (at_last) state_nx = ST_IDLE;
            end
            // A transfer on the last pixel tick reloads with no bubble.
            if (transfer) begin
                tile_nx  = tile_data;
                flip_nx  = tile_flip;
                addr_nx  = tile_x;
                cnt_nx   = '0;
                state_nx = ST_SHIFT;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!Reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            cnt      <= '0;
            tile_q   <= '0;
            flip_q   <= 1'b0;
            addr_q   <= '0;
            pix_out  <= '0;
            pix_addr <= '0;
            pix_we   <= 1'b0;
            buf_sel  <= 1'b0;
        end else begin
            cnt      <= cnt_nx;
            tile_q   <= tile_nx;
            flip_q   <= flip_nx;
            addr_q   <= addr_nx;
            pix_out  <= pix_out_nx;
            pix_addr <= pix_addr_nx;
            pix_we   <= pix_we_nx;
            buf_sel  <= buf_sel_nx;
        end
    end

endmodule
